// File: rtl/frequency_meter.sv
// frequency_meter: counts rising edges of an asynchronous input over a
// programmable window of gate_cycles clk cycles and publishes the count.
// Windows run back to back while enabled, so consecutive counts tile time.
module frequency_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  // Width of gate_cycles and the window counter. It normally equals WIDTH;
  // it is separate so that a narrow accumulator can still be given a long
  // window, which is the only way its saturation path can be reached.
  parameter int GATE_WIDTH  = WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sig_in,
  input  logic [GATE_WIDTH-1:0] gate_cycles,
  output logic [WIDTH-1:0]      edge_count,
  output logic                  count_valid,
  output logic                  overflow,
  output logic                  busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GATE = 1'b1;
  localparam logic [GATE_WIDTH-1:0] G_ONE = 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic [0:0]             r_state;
  logic [GATE_WIDTH-1:0]  r_g;
  logic [GATE_WIDTH-1:0]  r_win;
  logic [WIDTH-1:0]       r_acc;
  logic                   r_ovf;

  logic                   w_edge;
  logic                   w_start;
  logic                   w_last;
  logic [WIDTH:0]         w_sum;
  logic                   w_sat;
  logic [WIDTH-1:0]       w_acc_nxt;
  logic                   w_ovf_nxt;

  // Synchronize sig_in into clk domain, then delay once more for edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_dly;
  assign w_start   = enable && (gate_cycles != '0);
  assign w_last    = (r_win == (r_g - G_ONE));
  // Saturating add: the carry out marks that the window ran past full scale
  assign w_sum     = {1'b0, r_acc} + {{WIDTH{1'b0}}, w_edge};
  assign w_sat     = w_sum[WIDTH];
  assign w_acc_nxt = w_sat ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
  assign w_ovf_nxt = r_ovf | w_sat;
  assign busy      = (r_state == S_GATE);

  // Window FSM: open a window, accumulate edges, publish on the last cycle.
  // The last cycle doubles as the start cycle of the next window, which is
  // what makes back-to-back windows gapless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_g         <= '0;
      r_win       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      edge_count  <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_g     <= gate_cycles;
            r_win   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_GATE;
          end
        end
        S_GATE: begin
          if (w_last) begin
            edge_count  <= w_acc_nxt;
            overflow    <= w_ovf_nxt;
            count_valid <= 1'b1;
            r_win       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            if (w_start) r_g <= gate_cycles;
            else         r_state <= S_IDLE;
          end else if (!enable) begin
            // Abort: the partial window is dropped, published result kept
            r_state <= S_IDLE;
          end else begin
            r_win <= r_win + G_ONE;
            r_acc <= w_acc_nxt;
            r_ovf <= w_ovf_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
